nco_phase_gen: RTL and testbench
================================

NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL have parameter CORDIC_LATENCY, default 32, meaning cycles from angle/Xin/Yin sampled by the downstream CORDIC to its COS_OUT/SIN_OUT.
REQ-002 SHALL have parameter RATE_DIV, default 1, meaning clocks per generated sample (1..65535).
REQ-003 SHALL have parameter X_INIT, default 16'sd19898, meaning gain-compensated start vector 1/K*2^15.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse, begin generation.
REQ-007 SHALL have port stop  in  1  one-cycle pulse, end generation.
REQ-008 SHALL have port fcw_in  in  32  frequency control word; full circle = 2^32.
REQ-009 SHALL have port fcw_load  in  1  capture fcw_in.
REQ-010 SHALL have port phase_ofs  in  32  static phase offset added to the accumulator.
REQ-011 SHALL have port angle  out  32  angle to CORDIC; bits [31:30] = quadrant.
REQ-012 SHALL have port Xin  out  16  signed start X to CORDIC.
REQ-013 SHALL have port Yin  out  16  signed start Y to CORDIC.
REQ-014 SHALL have port angle_valid  out  1  angle is a new sample this cycle.
REQ-015 SHALL have port result_valid  out  1  CORDIC outputs this cycle belong to a valid sample.
REQ-016 SHALL have port busy  out  1  FSM not IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start; RUN -> DRAIN on stop; DRAIN -> IDLE when drain counter reaches CORDIC_LATENCY-1.
REQ-018 SHALL treat start in RUN/DRAIN as ignored; start and stop in the same cycle: stop wins (IDLE stays IDLE).
REQ-019 SHALL generate a sample tick every RATE_DIV clocks in RUN, the first tick on the cycle after entering RUN; divider counter cleared on entering RUN.
REQ-020 SHALL on each tick register angle = acc + phase_ofs (mod 2^32), then update acc = acc + fcw (mod 2^32, silent wrap).
REQ-021 SHALL assert angle_valid for exactly one clock per tick, registered, aligned with the new angle value.
REQ-022 SHALL drive Xin = X_INIT and Yin = 0 constantly.
REQ-023 SHALL delay angle_valid through a CORDIC_LATENCY-deep shift register that shifts every clock in all states; its output is result_valid.
REQ-024 SHALL capture fcw on fcw_load in any state; in RUN the new fcw is used from the next tick onward.
REQ-025 SHALL clear acc to 0 on IDLE -> RUN; angle holds its last value when no tick.
REQ-026 SHALL keep busy high in RUN and DRAIN so that result_valid pulses in flight complete before IDLE.

Reset
REQ-027 SHALL on rst: state IDLE, acc 0, fcw 0, angle 0, angle_valid 0, valid shift register all 0, result_valid 0, busy 0, divider 0; rst overrides start/stop/fcw_load in the same cycle, including mid-RUN.

Configuration
REQ-028 SHALL with NCO_SWEEP_EN defined add inputs sweep_step[31:0] and sweep_end[31:0]: after each tick fcw += sweep_step; if the new fcw > sweep_end (unsigned) fcw reloads the last fcw_load value; without NCO_SWEEP_EN those ports do not exist and fcw is constant between loads.

Structure
REQ-029 SHALL place FSM state typedef, ANGLE_W=32, XY_W=16 and default X_INIT in shared package nco_pkg.
REQ-030 SHALL implement the valid delay line as sub-module valid_delay_line (parameter DEPTH).

Verification
REQ-031 fcw=0x4000_0000, ofs=0, start -> angle 0x0,0x4000_0000,0x8000_0000,0xC000_0000,0x0 on consecutive ticks; first result_valid 32 clocks after first angle_valid.
REQ-032 fcw=0xFFFF_FFFF, ofs=0x1000_0000 -> angle 0x1000_0000,0x0FFF_FFFF,0x0FFF_FFFE (wrap-down).
REQ-033 RATE_DIV=4, fcw=1 -> angle_valid every 4th clock, angle increments by 1.
REQ-034 stop after 10 ticks -> angle_valid stops next cycle, busy high 32 clocks, 10 result_valid total, then IDLE.
REQ-035 rst pulse mid-RUN -> next cycle all outputs 0, no result_valid afterward; simultaneous start+stop in IDLE -> busy stays 0.
REQ-036 NCO_SWEEP_EN, fcw=0x100, step=0x100, end=0x300 -> fcw sequence 0x100,0x200,0x300,0x100.

Source files
------------

// File: rtl/nco_pkg.sv
// nco_pkg: shared types and constants for the NCO phase generator
package nco_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int ANGLE_W = 32;
  localparam int XY_W = 16;
  localparam logic signed [XY_W-1:0] X_INIT_DEF = 16'sd19898;
endpackage

// File: rtl/valid_delay_line.sv
// valid_delay_line: DEPTH-clock shift register for a valid flag, shifting every clock
module valid_delay_line #(
  parameter int DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  output logic valid_o
);
  logic [DEPTH-1:0] sr_q;
  logic [DEPTH:0] ext;
  assign ext = {sr_q, valid_i};
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else sr_q <= ext[DEPTH-1:0];
  end
  assign valid_o = sr_q[DEPTH-1];
endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase-accumulator angle source feeding a pipelined CORDIC.
// Optional NCO_SWEEP_EN adds a linear frequency sweep with wrap back to the loaded fcw.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int CORDIC_LATENCY = 32,
  parameter int RATE_DIV = 1,
  parameter logic signed [XY_W-1:0] X_INIT = X_INIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [ANGLE_W-1:0]        fcw_in,
  input  logic                      fcw_load,
  input  logic [ANGLE_W-1:0]        phase_ofs,
`ifdef NCO_SWEEP_EN
  input  logic [ANGLE_W-1:0]        sweep_step,
  input  logic [ANGLE_W-1:0]        sweep_end,
`endif
  output logic [ANGLE_W-1:0]        angle,
  output logic signed [XY_W-1:0]    Xin,
  output logic signed [XY_W-1:0]    Yin,
  output logic                      angle_valid,
  output logic                      result_valid,
  output logic                      busy
);
  localparam int CW = $clog2(CORDIC_LATENCY + 1);
  localparam logic [CW-1:0] DRAIN_MAX = CW'(CORDIC_LATENCY - 1);
  localparam logic [15:0] DIV_MAX = 16'(RATE_DIV - 1);
  state_e state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [CW-1:0] drain_q, drain_d;
  logic [ANGLE_W-1:0] acc_q, acc_d, fcw_q, fcw_d, angle_q, angle_d;
  logic av_q, go, tick;
  assign go = state_q == IDLE && start && !stop;
  // stop takes effect at once: no tick is issued on the edge that leaves RUN
  assign tick = state_q == RUN && !stop && div_q == '0;
  always_comb begin
    state_d = state_q;
    div_d = '0;
    drain_d = '0;
    unique case (state_q)
      IDLE: state_d = go ? RUN : IDLE;
      RUN: begin
        state_d = stop ? DRAIN : RUN;
        div_d = div_q == DIV_MAX ? '0 : div_q + 16'd1;
      end
      DRAIN: begin
        state_d = drain_q == DRAIN_MAX ? IDLE : DRAIN;
        drain_d = drain_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign acc_d = go ? '0 : tick ? acc_q + fcw_q : acc_q;
  assign angle_d = tick ? acc_q + phase_ofs : angle_q;
`ifdef NCO_SWEEP_EN
  logic [ANGLE_W-1:0] base_q, sweep_nx;
  assign sweep_nx = fcw_q + sweep_step;
  assign fcw_d = fcw_load ? fcw_in : tick ? (sweep_nx > sweep_end ? base_q : sweep_nx) : fcw_q;
  always_ff @(posedge clk) begin
    if (rst) base_q <= '0;
    else if (fcw_load) base_q <= fcw_in;
  end
`else
  assign fcw_d = fcw_load ? fcw_in : fcw_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      drain_q <= '0;
      acc_q <= '0;
      fcw_q <= '0;
      angle_q <= '0;
      av_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      drain_q <= drain_d;
      acc_q <= acc_d;
      fcw_q <= fcw_d;
      angle_q <= angle_d;
      av_q <= tick;
    end
  end
  valid_delay_line #(.DEPTH(CORDIC_LATENCY)) u_dly (
    .clk(clk),
    .rst(rst),
    .valid_i(av_q),
    .valid_o(result_valid)
  );
  assign angle = angle_q;
  assign angle_valid = av_q;
  assign busy = state_q != IDLE;
  assign Xin = X_INIT;
  assign Yin = '0;
endmodule

// File: tb/tb_nco_phase_gen.sv
// tb_nco_phase_gen: randomized bursts checked against an arithmetic phase model
module tb_nco_phase_gen;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, fcw_load = 1'b0;
  logic [31:0] fcw_in = '0, phase_ofs = '0;
  logic [31:0] angle;
  logic signed [15:0] xin, yin;
  logic av, rv, busy;
  logic start4 = 1'b0, stop4 = 1'b0, fcw_load4 = 1'b0;
  logic [31:0] fcw_in4 = '0, ofs4 = '0, angle4;
  logic signed [15:0] xin4, yin4;
  logic av4, rv4, busy4;
  int errs = 0, checks = 0, cyc = 0, rv_cnt = 0;
`ifdef NCO_SWEEP_EN
  logic [31:0] sweep_step = '0, sweep_end = '1;
`endif
  nco_phase_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fcw_in(fcw_in), .fcw_load(fcw_load),
    .phase_ofs(phase_ofs),
`ifdef NCO_SWEEP_EN
    .sweep_step(sweep_step), .sweep_end(sweep_end),
`endif
    .angle(angle), .Xin(xin), .Yin(yin), .angle_valid(av), .result_valid(rv), .busy(busy)
  );
  nco_phase_gen #(.CORDIC_LATENCY(8), .RATE_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .fcw_in(fcw_in4), .fcw_load(fcw_load4),
    .phase_ofs(ofs4),
`ifdef NCO_SWEEP_EN
    .sweep_step(32'd0), .sweep_end(32'hFFFF_FFFF),
`endif
    .angle(angle4), .Xin(xin4), .Yin(yin4), .angle_valid(av4), .result_valid(rv4), .busy(busy4)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rv) rv_cnt++;
  endtask
  // angle for tick k is ofs plus the sum of every fcw applied on earlier ticks
  task automatic burst(input logic [31:0] f, input logic [31:0] ofs, input int n,
                       input int ld_at, input logic [31:0] nf);
    logic [31:0] exp, cur, last;
    int base, av0, rv1, hi;
    fcw_in = f; fcw_load = 1'b1; phase_ofs = ofs;
    step();
    fcw_load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_av", {31'd0, av}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    base = rv_cnt; exp = ofs; cur = f; av0 = 0; rv1 = -1; last = ofs;
    for (int k = 0; k < n; k++) begin
      if (k == ld_at) begin fcw_in = nf; fcw_load = 1'b1; end
      step();
      fcw_load = 1'b0;
      if (k == 0) av0 = cyc;
      chk("tick_av", {31'd0, av}, 32'd1);
      chk("angle", angle, exp);
      last = exp;
      exp = exp + cur;
      if (k == ld_at) cur = nf;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_av", {31'd0, av}, 32'd0);
    chk("stop_hold", angle, last);
    hi = busy ? 1 : 0;
    for (int i = 0; i < 100 && busy; i++) begin
      step();
      if (rv && rv1 < 0) rv1 = cyc;
      if (busy) hi++;
    end
    chk("drain_end", {31'd0, busy}, 32'd0);
    chk("drain_len", hi, 32);
    chk("rv_count", rv_cnt - base, n);
    chk("rv_latency", rv1 - av0, 32);
    step();
    step();
    chk("rv_after_idle", rv_cnt - base, n);
  endtask
  initial begin
    int n, ld, base;
    step();
    step();
    chk("rst_angle", angle, 32'd0);
    chk("rst_av", {31'd0, av}, 32'd0);
    chk("rst_rv", {31'd0, rv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    chk("xin", {16'd0, xin}, 32'h4DBA);
    chk("yin", {16'd0, yin}, 32'd0);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", {31'd0, busy}, 32'd0);
    step();
    chk("start_stop_idle2", {31'd0, busy}, 32'd0);
    burst(32'h4000_0000, 32'h0, 5, -1, 32'h0);
    burst(32'hFFFF_FFFF, 32'h1000_0000, 3, -1, 32'h0);
    burst(32'h1, 32'h0, 10, -1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(3, 12);
      ld = (i % 2 == 1) ? int'($urandom_range(0, n - 2)) : -1;
      burst($urandom, $urandom, n, ld, $urandom);
    end
    fcw_in = 32'h1234_5678; fcw_load = 1'b1; phase_ofs = 32'h11;
    step();
    fcw_load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1; start = 1'b1; stop = 1'b1; fcw_load = 1'b1; fcw_in = 32'h5;
    step();
    rst = 1'b0; start = 1'b0; stop = 1'b0; fcw_load = 1'b0;
    chk("midrst_angle", angle, 32'd0);
    chk("midrst_av", {31'd0, av}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rv", {31'd0, rv}, 32'd0);
    base = rv_cnt;
    repeat (40) step();
    chk("midrst_no_rv", rv_cnt - base, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fcw_cleared", angle, 32'h11);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (40) step();
    chk("post_drain_idle", {31'd0, busy}, 32'd0);
    fcw_in4 = 32'd1; fcw_load4 = 1'b1;
    step();
    fcw_load4 = 1'b0; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("div4_av", {31'd0, av4}, ((i - 1) % 4 == 0) ? 32'd1 : 32'd0);
      if ((i - 1) % 4 == 0) chk("div4_angle", angle4, (i - 1) / 4);
    end
    stop4 = 1'b1;
    step();
    stop4 = 1'b0;
`ifdef NCO_SWEEP_EN
    sweep_step = 32'h100; sweep_end = 32'h300;
    fcw_in = 32'h100; fcw_load = 1'b1; phase_ofs = 32'h0;
    step();
    fcw_load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    begin
      logic [31:0] sw [5];
      sw = '{32'h0, 32'h100, 32'h300, 32'h600, 32'h700};
      for (int k = 0; k < 5; k++) begin
        step();
        chk("sweep_angle", angle, sw[k]);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (40) step();
    sweep_step = '0; sweep_end = '1;
`endif
    repeat (20) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
